// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control sequencer: class and phase
// encodings, control word field positions, the instruction-fetch word and the default HLT opcode.
package cu_pkg;

  typedef enum logic [1:0] {
    CLS_REG    = 2'b00,
    CLS_IMM    = 2'b01,
    CLS_MEM    = 2'b10,
    CLS_BRANCH = 2'b11
  } cu_class_e;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_HALT  = 2'd2
  } cu_phase_e;

  localparam int CW_W             = 37;
  localparam int PC_FS_LSB        = 0;
  localparam int PC_FS_W          = 2;
  localparam int PC_SEL_LSB       = 2;
  localparam int DATA_TRI_LSB     = 3;
  localparam int DATA_TRI_W       = 2;
  localparam int ADD_TRI_LSB      = 5;
  localparam int SIZE_LSB         = 6;
  localparam int SIZE_W           = 2;
  localparam int STATUS_LOAD_LSB  = 8;
  localparam int IR_LOAD_LSB      = 9;
  localparam int MEM_WRITE_EN_LSB = 10;
  localparam int B_SEL_LSB        = 11;
  localparam int MEM_CS_LSB       = 12;
  localparam int MEM_CS_W         = 2;
  localparam int C0_LSB           = 14;
  localparam int W_REG_LSB        = 15;
  localparam int DA_LSB           = 16;
  localparam int SB_LSB           = 21;
  localparam int SA_LSB           = 26;
  localparam int REG_ADDR_W       = 5;
  localparam int FS_LSB           = 31;
  localparam int FS_W             = 5;
  localparam int SPARE_LSB        = 36;

  // Fetch while memory is still busy: chip select, address and data buses only.
  localparam logic [CW_W-1:0] FETCH_CW = (CW_W'(2) << MEM_CS_LSB)
                                       | (CW_W'(1) << ADD_TRI_LSB)
                                       | (CW_W'(2) << DATA_TRI_LSB);
  // Extra bits once the fetched word is valid: load IR and advance the PC.
  localparam logic [CW_W-1:0] FETCH_DONE_CW = (CW_W'(1) << IR_LOAD_LSB)
                                            | (CW_W'(1) << PC_FS_LSB);

  localparam logic [10:0] HLT_OP_DEFAULT = 11'b11010100010;

endpackage

// File: rtl/cu_class_decode.sv
// Combinational instruction classifier: maps IR opcode bits to an execution class,
// flags the halt opcode, and flags instructions that fit no class.
module cu_class_decode
  import cu_pkg::*;
#(
  parameter logic [10:0] HLT_OP = HLT_OP_DEFAULT
) (
  input  logic [31:0] ir,
  output cu_class_e   cls,
  output logic        is_hlt,
  output logic        is_illegal
);

  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[20:0];

  // Overlapping patterns resolve in priority order: REG, IMM, BRANCH, MEM.
  always_comb begin
    cls        = CLS_REG;
    is_illegal = 1'b0;
    is_hlt     = (ir[31:21] == HLT_OP);
    if (ir[27:25] == 3'b101)      cls = CLS_REG;
    else if (ir[28:26] == 3'b100) cls = CLS_IMM;
    else if (ir[28:26] == 3'b101) cls = CLS_BRANCH;
    else if (ir[27] && !ir[25])   cls = CLS_MEM;
    else                          is_illegal = 1'b1;
  end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer: FETCH / EXEC / HALT phases, memory-wait stalls and
// control word muxing. Optional performance counters are built when CU_PERF_COUNT_EN is defined.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int          CUL    = 36,
  parameter logic [10:0] HLT_OP = HLT_OP_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  IR,
  input  logic         mem_ready,
  input  logic [CUL:0] cw_dec,
  input  logic [2:0]   ns_dec,
  input  logic [2:0]   k_dec,
  output logic [1:0]   class_sel,
  output logic [3:0]   state,
  output logic [CUL:0] controlWord,
  output logic [2:0]   k_mux,
  output logic         halted,
  output logic         illegal,
  output logic [31:0]  instr_count,
  output logic [31:0]  cycle_count
);

  cu_phase_e  phase_reg;
  cu_class_e  class_reg;
  logic [3:0] state_reg;
  logic       illegal_reg;

  cu_class_e  dec_class;
  logic       dec_hlt;
  logic       dec_illegal;

  cu_class_decode #(.HLT_OP(HLT_OP)) u_class_decode (
    .ir         (IR),
    .cls        (dec_class),
    .is_hlt     (dec_hlt),
    .is_illegal (dec_illegal)
  );

  logic stall;
  logic exec_done;
  logic nop_done;
  assign stall     = (phase_reg == PH_EXEC) && (cw_dec[MEM_CS_LSB +: MEM_CS_W] != '0) && !mem_ready;
  assign exec_done = (phase_reg == PH_EXEC) && !stall && (ns_dec == 3'd0);
  assign nop_done  = (phase_reg == PH_FETCH) && mem_ready && !dec_hlt && dec_illegal;

  assign class_sel = class_reg;
  assign state     = state_reg;
  assign illegal   = illegal_reg;
  assign halted    = (phase_reg == PH_HALT) && reset;

  always_comb begin
    controlWord = '0;
    k_mux       = '0;
    if (reset) begin
      case (phase_reg)
        PH_FETCH: begin
          controlWord = (CUL+1)'(FETCH_CW);
          if (mem_ready) controlWord = controlWord | (CUL+1)'(FETCH_DONE_CW);
        end
        PH_EXEC: begin
          controlWord      = cw_dec;
          controlWord[CUL] = 1'b0;
          k_mux            = k_dec;
          // A stalled memory step keeps its bus drive but must not commit anything.
          if (stall) begin
            controlWord[W_REG_LSB]                = 1'b0;
            controlWord[STATUS_LOAD_LSB]          = 1'b0;
            controlWord[IR_LOAD_LSB]              = 1'b0;
            controlWord[PC_FS_LSB +: PC_FS_W]     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_reg   <= PH_FETCH;
      class_reg   <= CLS_REG;
      state_reg   <= 4'd0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (phase_reg)
        PH_FETCH: begin
          if (mem_ready) begin
            if (dec_hlt) begin
              phase_reg <= PH_HALT;
            end else if (dec_illegal) begin
              illegal_reg <= 1'b1;
            end else begin
              phase_reg <= PH_EXEC;
              class_reg <= dec_class;
              state_reg <= 4'd0;
            end
          end
        end
        PH_EXEC: begin
          if (!stall) begin
            if (ns_dec != 3'd0) begin
              state_reg <= {1'b0, ns_dec};
            end else begin
              phase_reg <= PH_FETCH;
              state_reg <= 4'd0;
            end
          end
        end
        default: phase_reg <= PH_HALT;
      endcase
    end
  end

`ifdef CU_PERF_COUNT_EN
  logic [31:0] instr_count_reg;
  logic [31:0] cycle_count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_count_reg <= '0;
      cycle_count_reg <= '0;
    end else begin
      if (phase_reg != PH_HALT) cycle_count_reg <= cycle_count_reg + 32'd1;
      if (exec_done || nop_done) instr_count_reg <= instr_count_reg + 32'd1;
    end
  end

  assign instr_count = instr_count_reg;
  assign cycle_count = cycle_count_reg;
`else
  logic unused_perf;
  assign unused_perf = exec_done ^ nop_done;
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed and randomized instruction runs compared
// against a transaction-level model of fetch, classification, stepping, stalls and halt.
module tb_cu_sequencer;

  localparam logic [36:0] FETCH_WAIT = 37'h0_0000_2030;
  localparam logic [36:0] FETCH_GO   = 37'h0_0000_2231;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR = '0;
  logic        mem_ready = 1'b0;
  logic [36:0] cw_dec = '0;
  logic [2:0]  ns_dec = '0;
  logic [2:0]  k_dec = '0;
  logic [1:0]  class_sel;
  logic [3:0]  state;
  logic [36:0] controlWord;
  logic [2:0]  k_mux;
  logic        halted;
  logic        illegal;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;

  cu_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .IR          (IR),
    .mem_ready   (mem_ready),
    .cw_dec      (cw_dec),
    .ns_dec      (ns_dec),
    .k_dec       (k_dec),
    .class_sel   (class_sel),
    .state       (state),
    .controlWord (controlWord),
    .k_mux       (k_mux),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  int unsigned m_instr = 0;
  int unsigned m_cyc = 0;
  logic        m_ill = 1'b0;
  logic [1:0]  m_cls = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] rnd_cw();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[36:0];
  endfunction

  // -2 halt, -1 illegal, else class code 0..3
  function automatic int ref_class(input logic [31:0] ir);
    if (ir[31:21] == 11'b11010100010) return -2;
    if (ir[27:25] == 3'b101) return 0;
    if (ir[28:26] == 3'b100) return 1;
    if (ir[28:26] == 3'b101) return 3;
    if (ir[27] && !ir[25]) return 2;
    return -1;
  endfunction

  task automatic check_counters();
`ifdef CU_PERF_COUNT_EN
    chk("instr_count", 64'(instr_count), 64'(m_instr));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
`else
    chk("instr_count", 64'(instr_count), 64'd0);
    chk("cycle_count", 64'(cycle_count), 64'd0);
`endif
  endtask

  task automatic cyc(input logic [31:0] ir, input logic mr, input logic [36:0] cw,
                     input logic [2:0] ns, input logic [2:0] k, input logic [36:0] e_cw,
                     input logic [3:0] e_st, input logic [2:0] e_k, input logic e_halt);
    @(negedge clock);
    IR = ir; mem_ready = mr; cw_dec = cw; ns_dec = ns; k_dec = k;
    #1;
    chk("controlWord", 64'(controlWord), 64'(e_cw));
    chk("state", 64'(state), 64'(e_st));
    chk("class_sel", 64'(class_sel), 64'(m_cls));
    chk("k_mux", 64'(k_mux), 64'(e_k));
    chk("halted", 64'(halted), 64'(e_halt));
    chk("illegal", 64'(illegal), 64'(m_ill));
    check_counters();
    m_ill = 1'b0;
    if (!e_halt) m_cyc++;
  endtask

  task automatic fetch(input logic [31:0] ir, input int waits);
    for (int w = 0; w < waits; w++)
      cyc(ir, 1'b0, rnd_cw(), 3'($urandom), 3'($urandom), FETCH_WAIT, 4'd0, 3'd0, 1'b0);
    cyc(ir, 1'b1, rnd_cw(), 3'($urandom), 3'($urandom), FETCH_GO, 4'd0, 3'd0, 1'b0);
  endtask

  task automatic stall_cycle(input logic [2:0] st);
    logic [36:0] cw;
    logic [36:0] e;
    logic [2:0]  k;
    cw = rnd_cw();
    if (cw[13:12] == 2'b00) cw[13] = 1'b1;
    e = cw; e[36] = 1'b0; e[15] = 1'b0; e[9] = 1'b0; e[8] = 1'b0; e[1:0] = 2'b00;
    k = 3'($urandom);
    cyc($urandom(), 1'b0, cw, 3'($urandom), k, e, {1'b0, st}, k, 1'b0);
  endtask

  task automatic step_cycle(input logic [2:0] st, input logic [2:0] nxt, input logic force_ready);
    logic [36:0] cw;
    logic [36:0] e;
    logic [2:0]  k;
    logic        mr;
    cw = rnd_cw();
    mr = 1'b1;
    if (!force_ready && $urandom_range(1, 0) == 0) begin
      cw[13:12] = 2'b00;
      mr = 1'($urandom);
    end
    e = cw; e[36] = 1'b0;
    k = 3'($urandom);
    cyc($urandom(), mr, cw, nxt, k, e, {1'b0, st}, k, 1'b0);
  endtask

  task automatic run_instr(input logic [31:0] ir, input int waits, input int nsteps, input int max_stall);
    int         c;
    int         stalls;
    logic [2:0] st;
    logic [2:0] nxt;
    c = ref_class(ir);
    fetch(ir, waits);
    if (c == -1) begin
      m_ill = 1'b1;
      m_instr++;
    end else if (c >= 0) begin
      m_cls = 2'(c);
      st = 3'd0;
      for (int i = 0; i < nsteps; i++) begin
        nxt = (i == nsteps - 1) ? 3'd0 : 3'($urandom_range(7, 1));
        stalls = $urandom_range(max_stall, 0);
        for (int s = 0; s < stalls; s++) stall_cycle(st);
        step_cycle(st, nxt, 1'b0);
        st = nxt;
      end
      m_instr++;
    end
  endtask

  task automatic reset_pulse(input int hold);
    @(negedge clock);
    #2 reset = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      #1;
      chk("rst_controlWord", 64'(controlWord), 64'd0);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_class_sel", 64'(class_sel), 64'd0);
      chk("rst_k_mux", 64'(k_mux), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_instr_count", 64'(instr_count), 64'd0);
      chk("rst_cycle_count", 64'(cycle_count), 64'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    m_cls = 2'b00; m_instr = 0; m_cyc = 0; m_ill = 1'b0;
  endtask

  initial begin
    logic [31:0] ir;

    // Power-on reset
    reset_pulse(1);

    // ADD: one fetch cycle, one exec cycle, back to fetch
    run_instr(32'h8B00_0000, 0, 1, 0);
    fetch(32'h9100_0000, 0);
    m_cls = 2'b01;
    step_cycle(3'd0, 3'd0, 1'b1);
    m_instr++;

    // LDUR: step 1 stalls three cycles
    fetch(32'hF840_0000, 0);
    m_cls = 2'b10;
    step_cycle(3'd0, 3'd1, 1'b1);
    for (int s = 0; s < 3; s++) stall_cycle(3'd1);
    step_cycle(3'd1, 3'd0, 1'b1);
    m_instr++;

    // Fetch waits two cycles, then branch classes
    run_instr(32'h1400_0000, 2, 2, 1);
    run_instr(32'hB400_0000, 1, 3, 2);

    // Illegal instruction: one-cycle pulse and straight back to fetch
    run_instr(32'h0000_0000, 0, 1, 0);
    run_instr(32'h8B00_0000, 0, 1, 0);

    // Randomized instruction stream, halt opcode excluded
    for (int n = 0; n < 60; n++) begin
      ir = $urandom();
      if (ir[31:21] == 11'b11010100010) ir[31] = 1'b0;
      run_instr(ir, $urandom_range(2, 0), $urandom_range(4, 1), $urandom_range(3, 0));
    end

    // Reset in the middle of a stall in step 2
    fetch(32'hF840_0000, 1);
    m_cls = 2'b10;
    step_cycle(3'd0, 3'd1, 1'b1);
    step_cycle(3'd1, 3'd2, 1'b1);
    stall_cycle(3'd2);
    reset_pulse(0);
    run_instr(32'h8B00_0000, 0, 1, 0);

    // HLT: outputs parked, counters frozen until reset
    fetch(32'hD440_0000, 1);
    for (int h = 0; h < 8; h++)
      cyc($urandom(), 1'($urandom), rnd_cw(), 3'($urandom), 3'($urandom), 37'd0, 4'd0, 3'd0, 1'b1);
    reset_pulse(1);
    run_instr(32'h9100_0000, 1, 2, 1);
    run_instr(32'hF840_0000, 0, 3, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Multi-cycle control sequencer for the CPU datapath. Owns the control state register, issues the instruction-fetch control word, classifies the fetched instruction, and steps the selected class decoder (R-type, immediate, load/store, branch) through its execution states via the decoders' next-state output. Stalls on memory wait, detects HLT, and drives the final 37-bit control word, `k_mux` and `state` into the datapath.

## Interface
- `CUL`, 36: control word MSB index (word is `CUL+1` bits).
- `HLT_OP`, 11'b11010100010: `IR[31:21]` value that halts the core.
- `clock`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted 0 forces reset state immediately.
- `IR`  in  32  instruction register contents.
- `mem_ready`  in  1  memory access complete this cycle; tie 1 for single-cycle memory.
- `cw_dec`  in  CUL+1  control word from decoder bank for (`class_sel`, `state`).
- `ns_dec`  in  3  decoder next state; 0 = last step.
- `k_dec`  in  3  decoder constant select.
- `class_sel`  out  2  00 REG, 01 IMM, 10 MEM, 11 BRANCH.
- `state`  out  4  execution step index presented to decoders.
- `controlWord`  out  CUL+1  final datapath control word.
- `k_mux`  out  3  constant select to datapath.
- `halted`  out  1  core stopped on HLT.
- `illegal`  out  1  one-cycle pulse on unclassifiable instruction.
- `instr_count`, `cycle_count`  out  32 each  performance counters (see Configuration).

## Operation
- Control word bit map: PC_FS[1:0], PC_sel[2], data_tri_sel[4:3], add_tri_sel[5], size[7:6], status_load[8], IR_load[9], mem_write_en[10], B_Sel[11], mem_cs[13:12], C0[14], w_reg[15], DA[20:16], SB[25:21], SA[30:26], FS[35:31], bit 36 spare = 0.
- FSM phases: FETCH, EXEC, HALT. Reset → FETCH, `state`=0.
- FETCH word: mem_cs=10, add_tri_sel=1, data_tri_sel=10, all else 0; IR_load=1 and PC_FS=01 only in the cycle `mem_ready`=1. Leave FETCH when `mem_ready`=1.
- On FETCH exit, next cycle enters EXEC with `state`=0; `class_sel` latched from new IR: `IR[27:25]`=101 → REG; `IR[28:26]`=100 → IMM; `IR[28:26]`=101 → BRANCH; `IR[27]`=1 and `IR[25]`=0 → MEM; first match wins in that order.
- HLT check precedes classification: opcode == `HLT_OP` → HALT. No match → `illegal` pulse, return to FETCH (NOP).
- EXEC: `controlWord`=`cw_dec`, `k_mux`=`k_dec`. If `cw_dec` mem_cs≠00 and `mem_ready`=0: stall — hold `state`, force w_reg, status_load, IR_load to 0 and PC_FS to 00; mem_write_en and addresses stay driven. Otherwise `ns_dec`≠0 → `state`=`ns_dec`; `ns_dec`=0 → FETCH.
- HALT: `controlWord`=0, `k_mux`=0, `halted`=1; exit only by reset.

## Timing
- Reset values: `controlWord`=0, `k_mux`=0, `state`=0, `class_sel`=00, `halted`=0, `illegal`=0, counters 0.
- Outputs combinational from registered phase/step/class plus `mem_ready` and decoder inputs; no added latency.
- Single-step R-type: 2 cycles per instruction (FETCH + EXEC) with `mem_ready`=1.
- Each stalled cycle adds exactly one cycle; no step is skipped or repeated.
- `ns_dec` values ≥8 impossible (3 bits); `state[3]` always 0.
- Reset during stall or HALT returns to FETCH asynchronously; no pending write completes.

## Configuration
- `CU_PERF_COUNT_EN` defined: `cycle_count` increments every cycle outside HALT; `instr_count` increments on each EXEC→FETCH transition and on illegal-NOP; both wrap at 2^32.
- Not defined: counter logic omitted, both ports driven constant 0.

## Structure
- Package `cu_pkg`: class encodings, phase enum, control word field LSB/width constants, FETCH control word constant, default `HLT_OP`.
- One sub-module: `cu_class_decode` (combinational IR → class, is_hlt, is_illegal).

## Test plan
- ADD R-type, `mem_ready`=1, `ns_dec`=0 → FETCH word with IR_load=1 cycle 0, `cw_dec` passed cycle 1, FETCH again cycle 2; `instr_count`=1.
- LDUR with decoder `ns_dec` 0→1→0, `mem_ready` low 3 cycles in step 1 → `state` holds 1 for 4 cycles, w_reg=0 until ready, total 5 cycles.
- Fetch with `mem_ready` low 2 cycles → PC_FS=00, IR_load=0 both cycles, then PC_FS=01, IR_load=1 once.
- IR=0xD4400000 → `halted`=1, `controlWord`=0 indefinitely; `cycle_count` frozen; reset low → FETCH.
- IR=0x00000000 → one-cycle `illegal`, return to FETCH, no EXEC cycle.
- Reset asserted mid-stall in EXEC step 2 → all outputs zero same cycle, FETCH after release.
